bus8_ac_pulse_train: RTL

//  Consumer of one Bus8 Autoclear channel. Runs one finite event per start:
//  a train of N pulses with programmable high and low widths.

---
 rtl/bus8_ac_pulse_train.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus8_ac_pulse_train.sv
// Autoclear channel consumer: on each Start rising edge, emits a train of N
// pulses with programmable high/low widths and returns a one-cycle Done.
module bus8_ac_pulse_train #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_WIDTH = 8
) (
  input  logic                 i_Bus_Clk,
  input  logic                 i_Bus_Rst,
  input  logic                 i_AC_Start,
  input  logic [NUM_WIDTH-1:0] i_Num_Pulses,
  input  logic [CNT_WIDTH-1:0] i_High_Cyc,
  input  logic [CNT_WIDTH-1:0] i_Low_Cyc,
  output logic                 o_AC_Done,
  output logic                 o_Pulse,
  output logic                 o_Busy,
  output logic [NUM_WIDTH-1:0] o_Pulse_Idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [NUM_WIDTH-1:0] NUM_ZERO = '0;
  localparam logic [NUM_WIDTH-1:0] NUM_ONE  = NUM_WIDTH'(1);

  state_t               state;
  logic                 start_d;
  logic [NUM_WIDTH-1:0] num_lat;
  logic [CNT_WIDTH-1:0] high_lat;
  logic [CNT_WIDTH-1:0] low_lat;
  logic [CNT_WIDTH-1:0] phase_cnt;
  logic [NUM_WIDTH-1:0] idx;

  logic start_edge;
  logic high_last;
  logic low_last;
  logic last_pulse;

  always_comb begin
    start_edge = i_AC_Start && !start_d;
    high_last  = (phase_cnt == high_lat - CNT_ONE);
    low_last   = (phase_cnt == low_lat - CNT_ONE);
    last_pulse = (idx == num_lat - NUM_ONE);
  end

  assign o_Pulse_Idx = idx;

  // NOTE: every register here uses non-blocking assignment so all flops
  // update together from the same pre-edge values.
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      num_lat   <= NUM_ZERO;
      high_lat  <= CNT_ONE;
      low_lat   <= CNT_ONE;
      phase_cnt <= CNT_ZERO;
      idx       <= NUM_ZERO;
      o_AC_Done <= 1'b0;
      o_Pulse   <= 1'b0;
      o_Busy    <= 1'b0;
    end else begin
      start_d   <= i_AC_Start;
      o_AC_Done <= 1'b0;

      unique case (state)
        IDLE: begin
          phase_cnt <= CNT_ZERO;
          idx       <= NUM_ZERO;
          if (start_edge) begin
            // Zero widths would never terminate a phase; run them as one clock.
            num_lat  <= i_Num_Pulses;
            high_lat <= (i_High_Cyc == CNT_ZERO) ? CNT_ONE : i_High_Cyc;
            low_lat  <= (i_Low_Cyc == CNT_ZERO) ? CNT_ONE : i_Low_Cyc;
            if (i_Num_Pulses == NUM_ZERO) begin
              o_AC_Done <= 1'b1;
            end else begin
              state   <= HIGH;
              o_Pulse <= 1'b1;
              o_Busy  <= 1'b1;
            end
          end
        end

        HIGH: begin
          if (!i_AC_Start) begin
            state     <= IDLE;
            o_Pulse   <= 1'b0;
            o_Busy    <= 1'b0;
            idx       <= NUM_ZERO;
            phase_cnt <= CNT_ZERO;
          end else if (high_last) begin
            phase_cnt <= CNT_ZERO;
            o_Pulse   <= 1'b0;
            if (last_pulse) begin
              state     <= IDLE;
              o_Busy    <= 1'b0;
              o_AC_Done <= 1'b1;
              idx       <= NUM_ZERO;
            end else begin
              state <= LOW;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_ONE;
          end
        end

        LOW: begin
          if (!i_AC_Start) begin
            state     <= IDLE;
            o_Pulse   <= 1'b0;
            o_Busy    <= 1'b0;
            idx       <= NUM_ZERO;
            phase_cnt <= CNT_ZERO;
          end else if (low_last) begin
            state     <= HIGH;
            phase_cnt <= CNT_ZERO;
            o_Pulse   <= 1'b1;
            idx       <= idx + NUM_ONE;
          end else begin
            phase_cnt <= phase_cnt + CNT_ONE;
          end
        end

        default: begin
          state   <= IDLE;
          o_Pulse <= 1'b0;
          o_Busy  <= 1'b0;
          idx     <= NUM_ZERO;
        end
      endcase
    end
  end

endmodule
